// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the irrigation mm:ss countdown controller.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEC_T_W = 3;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [SEC_T_W-1:0] SEC_T_MAX = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    RUNNING,
    PAUSED,
    EXPIRED
  } timer_state_t;

  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v);
    return (v > DIGIT_MAX) ? DIGIT_MAX : v;
  endfunction

  function automatic logic [SEC_T_W-1:0] sat_sec_t(input logic [SEC_T_W-1:0] v);
    return (v > SEC_T_MAX) ? SEC_T_MAX : v;
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Command/preset and status bundle between front panel, timer controller and valve driver.
interface countdown_timer_ctrl_if;
  import timer_pkg::*;

  logic               tick;
  logic               load;
  logic               start;
  logic               pause;
  logic               clear;
  logic [DIGIT_W-1:0] preset_min_t;
  logic [DIGIT_W-1:0] preset_min_u;
  logic [SEC_T_W-1:0] preset_sec_t;
  logic [DIGIT_W-1:0] preset_sec_u;
  logic [DIGIT_W-1:0] min_t;
  logic [DIGIT_W-1:0] min_u;
  logic [SEC_T_W-1:0] sec_t;
  logic [DIGIT_W-1:0] sec_u;
  logic               valve_en;
  logic               busy;
  logic               expired;

  modport master (
    output tick, load, start, pause, clear,
    output preset_min_t, preset_min_u, preset_sec_t, preset_sec_u,
    input  min_t, min_u, sec_t, sec_u, valve_en, busy, expired
  );

  modport slave (
    input  tick, load, start, pause, clear,
    input  preset_min_t, preset_min_u, preset_sec_t, preset_sec_u,
    output min_t, min_u, sec_t, sec_u, valve_en, busy, expired
  );

endinterface

// File: rtl/countdown_timer_ctrl_down_digit.sv
// One down-counting digit of the countdown chain; wraps 0 -> MAX and flags a borrow.
module down_digit #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             borrow
);

  assign borrow = dec & (q == '0);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= (q == '0) ? MAX : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown sequencer: loads an mm:ss preset, counts down on 1 Hz ticks and drives the valve.
module countdown_timer_ctrl
  import timer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  countdown_timer_ctrl_if.slave bus
);

  timer_state_t       state;
  logic [DIGIT_W-1:0] mt_q, mu_q, su_q;
  logic [SEC_T_W-1:0] st_q;
  logic               su_borrow, st_borrow, mu_borrow, mt_borrow;
  logic               load_ok, dec_en, zero, expiring;
  logic               valve_en_q, busy_q, expired_q;

  // Load is refused while running; clear overrides it.
  assign load_ok  = bus.load & ~bus.clear & (state != RUNNING);
  assign dec_en   = (state == RUNNING) & bus.tick & ~bus.pause & ~bus.start
                    & ~bus.clear & ~bus.load;
  assign zero     = (mt_q == '0) & (mu_q == '0) & (st_q == '0) & (su_q == '0);
  assign expiring = dec_en & (mt_q == '0) & (mu_q == '0) & (st_q == '0)
                    & (su_q == DIGIT_W'(1));

  down_digit #(.WIDTH(DIGIT_W), .MAX(DIGIT_MAX)) u_sec_u (
    .clock(clock), .reset(reset), .load(load_ok), .load_val(sat_digit(bus.preset_sec_u)),
    .dec(dec_en), .clr(bus.clear), .q(su_q), .borrow(su_borrow)
  );

  down_digit #(.WIDTH(SEC_T_W), .MAX(SEC_T_MAX)) u_sec_t (
    .clock(clock), .reset(reset), .load(load_ok), .load_val(sat_sec_t(bus.preset_sec_t)),
    .dec(su_borrow), .clr(bus.clear), .q(st_q), .borrow(st_borrow)
  );

  down_digit #(.WIDTH(DIGIT_W), .MAX(DIGIT_MAX)) u_min_u (
    .clock(clock), .reset(reset), .load(load_ok), .load_val(sat_digit(bus.preset_min_u)),
    .dec(st_borrow), .clr(bus.clear), .q(mu_q), .borrow(mu_borrow)
  );

  down_digit #(.WIDTH(DIGIT_W), .MAX(DIGIT_MAX)) u_min_t (
    .clock(clock), .reset(reset), .load(load_ok), .load_val(sat_digit(bus.preset_min_t)),
    .dec(mu_borrow), .clr(bus.clear), .q(mt_q), .borrow(mt_borrow)
  );

  // mt_borrow can only fire from 00:00 in RUNNING, which the FSM never allows; treated as expiry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valve_en_q <= 1'b0;
      busy_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.clear) begin
        state      <= IDLE;
        valve_en_q <= 1'b0;
        busy_q     <= 1'b0;
      end else if (load_ok) begin
        state      <= LOADED;
        valve_en_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          LOADED: if (bus.start && !bus.pause && !zero) begin
            state      <= RUNNING;
            valve_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
          PAUSED: if (bus.start && !bus.pause) begin
            state      <= RUNNING;
            valve_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end
          RUNNING: if (bus.pause) begin
            state      <= PAUSED;
            valve_en_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (expiring || mt_borrow) begin
            state      <= EXPIRED;
            valve_en_q <= 1'b0;
            busy_q     <= 1'b0;
            expired_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.min_t    = mt_q;
  assign bus.min_u    = mu_q;
  assign bus.sec_t    = st_q;
  assign bus.sec_u    = su_q;
  assign bus.valve_en = valve_en_q;
  assign bus.busy     = busy_q;
  assign bus.expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl.
module tb_countdown_timer_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  countdown_timer_ctrl_if bus ();

  countdown_timer_ctrl dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pack(input int unsigned mt, input int unsigned mu,
                                       input int unsigned st, input int unsigned su);
    return {17'd0, 4'(mt), 4'(mu), 3'(st), 4'(su)};
  endfunction

  function automatic logic [31:0] digits();
    return {17'd0, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic v, input logic b, input logic e);
    check_val({tag, ".valve_en"}, 32'(bus.valve_en), 32'(v));
    check_val({tag, ".busy"},     32'(bus.busy),     32'(b));
    check_val({tag, ".expired"},  32'(bus.expired),  32'(e));
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    bus.tick  = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] mt, input logic [3:0] mu,
                         input logic [2:0] st, input logic [3:0] su);
    bus.preset_min_t = mt;
    bus.preset_min_u = mu;
    bus.preset_sec_t = st;
    bus.preset_sec_u = su;
    bus.load = 1'b1;
    cycle();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cycle();
  endtask

  task automatic do_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cycle();
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0;
    bus.preset_min_t = '0; bus.preset_min_u = '0; bus.preset_sec_t = '0; bus.preset_sec_u = '0;
    cycle();
    cycle();
    reset = 1'b0;
    check_val("reset.digits", digits(), pack(0, 0, 0, 0));
    check_flags("reset", 1'b0, 1'b0, 1'b0);

    // 00:03 countdown to expiry
    do_load(0, 0, 0, 3);
    check_val("t1.load", digits(), pack(0, 0, 0, 3));
    check_flags("t1.loaded", 1'b0, 1'b0, 1'b0);
    do_start();
    check_flags("t1.start", 1'b1, 1'b1, 1'b0);
    do_ticks(1);
    check_val("t1.tick1", digits(), pack(0, 0, 0, 2));
    do_ticks(1);
    check_val("t1.tick2", digits(), pack(0, 0, 0, 1));
    check_flags("t1.tick2", 1'b1, 1'b1, 1'b0);
    do_ticks(1);
    check_val("t1.tick3", digits(), pack(0, 0, 0, 0));
    check_flags("t1.expire", 1'b0, 1'b0, 1'b1);
    do_ticks(1);
    check_val("t1.tick_in_expired", digits(), pack(0, 0, 0, 0));
    check_flags("t1.after", 1'b0, 1'b0, 1'b0);

    // Full borrow chains
    do_load(0, 1, 0, 0);
    do_start();
    do_ticks(1);
    check_val("t2.borrow_min_u", digits(), pack(0, 0, 5, 9));
    bus.clear = 1'b1;
    cycle();
    check_val("t2.clear", digits(), pack(0, 0, 0, 0));
    check_flags("t2.clear", 1'b0, 1'b0, 1'b0);
    do_load(1, 0, 0, 0);
    do_start();
    do_ticks(1);
    check_val("t2.borrow_min_t", digits(), pack(0, 9, 5, 9));

    // Pause coincident with tick, then resume
    do_load(0, 0, 1, 0);
    check_flags("t3.load_from_running_ignored?", 1'b1, 1'b1, 1'b0);
    check_val("t3.load_ignored", digits(), pack(0, 9, 5, 9));
    bus.clear = 1'b1;
    cycle();
    do_load(0, 0, 1, 0);
    do_start();
    do_ticks(2);
    check_val("t3.two_ticks", digits(), pack(0, 0, 0, 8));
    bus.pause = 1'b1;
    bus.tick  = 1'b1;
    cycle();
    check_val("t3.pause_tick", digits(), pack(0, 0, 0, 8));
    check_flags("t3.paused", 1'b0, 1'b1, 1'b0);
    do_ticks(1);
    check_val("t3.tick_paused", digits(), pack(0, 0, 0, 8));
    do_start();
    check_flags("t3.resume", 1'b1, 1'b1, 1'b0);
    check_val("t3.resume", digits(), pack(0, 0, 0, 8));
    do_ticks(7);
    check_val("t3.seven", digits(), pack(0, 0, 0, 1));
    check_flags("t3.seven", 1'b1, 1'b1, 1'b0);
    do_ticks(1);
    check_flags("t3.expire", 1'b0, 1'b0, 1'b1);

    // Preset saturation and start at zero
    do_load(15, 12, 7, 15);
    check_val("t4.saturate", digits(), pack(9, 9, 5, 9));
    do_load(0, 0, 0, 0);
    do_start();
    check_flags("t4.start_zero", 1'b0, 1'b0, 1'b0);
    do_ticks(1);
    check_val("t4.zero_tick", digits(), pack(0, 0, 0, 0));
    check_flags("t4.zero_tick", 1'b0, 1'b0, 1'b0);

    // Clear coincident with expiring tick
    do_load(0, 0, 0, 2);
    do_start();
    do_ticks(1);
    check_val("t5.one_left", digits(), pack(0, 0, 0, 1));
    bus.clear = 1'b1;
    bus.tick  = 1'b1;
    cycle();
    check_val("t5.clear_tick", digits(), pack(0, 0, 0, 0));
    check_flags("t5.clear_tick", 1'b0, 1'b0, 1'b0);
    cycle();
    check_flags("t5.no_late_pulse", 1'b0, 1'b0, 1'b0);

    // Reset mid-count at 05:42
    do_load(0, 5, 4, 3);
    do_start();
    do_ticks(1);
    check_val("t6.count", digits(), pack(0, 5, 4, 2));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("t6.reset", digits(), pack(0, 0, 0, 0));
    check_flags("t6.reset", 1'b0, 1'b0, 1'b0);
    do_ticks(3);
    check_val("t6.ticks_idle", digits(), pack(0, 0, 0, 0));
    check_flags("t6.ticks_idle", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
